shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (Rijndael block = 32*NB bits); legal values are 4, 6 and 8.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have the port flush, input, 1 bit: synchronous clear of all buffered entries.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: input transaction present.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block can accept an input transaction this cycle.
REQ-007 The block SHALL have the port in_inv, input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows.
REQ-008 The block SHALL have the port in_state, input, 32*NB bits: the state, column-major; byte (r,c) occupies bits [32*NB-1-8*(4c+r) -: 8].
REQ-009 The block SHALL have the port out_valid, output, 1 bit: output transaction present.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the output.
REQ-011 The block SHALL have the port out_inv, output, 1 bit: the mode bit of the head entry.
REQ-012 The block SHALL have the port out_state, output, 32*NB bits: the permuted state of the head entry.
REQ-013 The block SHALL have the port occupancy, output, 2 bits: the number of buffered entries, 0 to 2.

Function
REQ-014 Row offsets SHALL be off0=0, off1=1, off2=2 and off3=3 for NB=4 and NB=6, and off0=0, off1=1, off2=3 and off3=4 for NB=8.
REQ-015 In forward mode (in_inv=0), out(r,c) SHALL equal in(r,(c+off_r) mod NB).
REQ-016 In inverse mode (in_inv=1), out(r,c) SHALL equal in(r,(c-off_r+NB) mod NB).
REQ-017 The permutation SHALL be applied at input acceptance, and the buffer SHALL store the permuted state together with its mode bit.
REQ-018 An input SHALL be accepted only when in_valid=1 and in_ready=1; out_valid, out_inv and out_state SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 The buffer SHALL be a 2-entry in-order buffer, with in_ready = (occupancy<2) and no combinational path from out_ready to in_ready.
REQ-020 Latency SHALL be one cycle: an input accepted in cycle t into an empty buffer appears with out_valid=1 in cycle t+1.
REQ-021 When out_valid=1 and out_ready=1, the head entry SHALL be popped in that cycle.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-023 When occupancy=2, pushes SHALL be blocked (in_ready=0) even if a pop occurs in the same cycle; in_ready SHALL rise in the following cycle.
REQ-024 When occupancy=0, out_valid SHALL be 0 and out_state SHALL not be consumed; out_ready SHALL be ignored.
REQ-025 flush=1 SHALL set occupancy to 0 at the next edge, and an input presented in the same cycle SHALL be dropped; flush has priority over push and pop.
REQ-026 Per-transaction mode SHALL be honoured, so that consecutive forward and inverse transactions may be interleaved without bubbles.
REQ-027 Back-to-back throughput SHALL be one transaction per cycle when out_ready is held at 1.
REQ-028 An NB value other than 4, 6 or 8 SHALL cause an elaboration-time error.

Reset
REQ-029 rst_n=0 SHALL immediately, asynchronously, force occupancy=0, out_valid=0, out_inv=0, out_state=0 and in_ready=1 after deassertion.
REQ-030 Reset asserted mid-stream SHALL discard all buffered entries, and no partial entry SHALL appear after reset.
REQ-031 Reset deassertion SHALL be synchronised externally, and the block SHALL accept input in the first cycle after rst_n rises.

Structure
REQ-032 The package aes_pkg SHALL hold the legal-NB check, the row-offset function off(NB,r) and the byte-index helper.
REQ-033 The combinational permutation SHALL be a sub-module shift_rows_perm (parameter NB; in_state, inv -> out_state), instantiated once before the buffer.
REQ-034 The buffer SHALL use registers, not memory macros; the state width SHALL be 32*NB bits throughout.

Verification
REQ-035 With NB=4, forward mode, in_state=000102030405060708090a0b0c0d0e0f -> out_state=00050a0f04090e03080d02070c01060b, out_inv=0, one cycle later.
REQ-036 With NB=4, inverse mode, the same input -> out_state=000d0a0704010e0b0805020f0c090603; a forward transaction followed by an inverse one returns the original state.
REQ-037 With NB=6 and NB=8, random states in each mode -> the bench SHALL check against a reference model using the REQ-014 offsets; for NB=8, row 2 SHALL move by 3 and row 3 by 4.
REQ-038 With out_ready=0 and 3 inputs pushed -> occupancy=2, in_ready=0, out_state stable; out_ready=1 then drains the entries in order, and in_ready returns one cycle after the first pop.
REQ-039 flush=1 with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, and the input is dropped.
REQ-040 rst_n pulsed low mid-stream -> outputs go to zero asynchronously, and the next accepted input emerges with one-cycle latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Rijndael ShiftRows helpers: legal block widths, per-row rotation amounts and
// the bit position of state byte (r,c) in a column-major, MSB-first state vector.
package aes_pkg;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rows 2 and 3 rotate one extra position only for the 256-bit block.
  function automatic int off(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Byte (r,c) is byte number 4c+r counted from the MSB end.
  function automatic int byte_lsb(input int nb, input int r, input int c);
    return 32 * nb - 8 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; pure wiring plus a
// per-byte 2:1 mux on the mode bit.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  input  logic             inv,
  output logic [32*NB-1:0] out_state
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_F = (c + off(NB, r)) % NB;
      localparam int SRC_I = (c - off(NB, r) + NB) % NB;
      assign out_state[byte_lsb(NB, r, c) +: 8] = inv ? in_state[byte_lsb(NB, r, SRC_I) +: 8]
                                                      : in_state[byte_lsb(NB, r, SRC_F) +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows/InvShiftRows applied at acceptance into a 2-entry in-order register buffer.
// One-cycle latency; in_ready depends only on registered occupancy, so out_ready never reaches it.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_state,
  output logic [1:0]        occupancy
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  typedef struct packed {
    logic         inv;
    logic [W-1:0] state;
  } entry_t;

  logic [W-1:0] perm_state;
  entry_t       perm_ent;
  entry_t       head_q, head_d;
  entry_t       tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  shift_rows_perm #(.NB(NB)) u_perm (
    .in_state  (in_state),
    .inv       (in_inv),
    .out_state (perm_state)
  );

  assign perm_ent  = '{inv: in_inv, state: perm_state};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_inv   = head_q.inv;
  assign out_state = head_q.state;
  assign occupancy = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A simultaneous push and pop can only happen at count 1, so the new entry becomes the head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: head_d = perm_ent;
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = perm_ent;
          else                 tail_d = perm_ent;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench: stimulus queues expected entries, a negedge monitor pops and compares.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic zero = 1'b0;

  logic         in_valid4 = 0, in_inv4 = 0, out_ready4 = 0;
  logic [127:0] in_state4 = '0;
  logic         in_ready4, out_valid4, out_inv4;
  logic [127:0] out_state4;
  logic [1:0]   occ4;

  logic         in_valid6 = 0, in_inv6 = 0, out_ready6 = 1;
  logic [191:0] in_state6 = '0;
  logic         in_ready6, out_valid6, out_inv6;
  logic [191:0] out_state6;
  logic [1:0]   occ6;

  logic         in_valid8 = 0, in_inv8 = 0, out_ready8 = 1;
  logic [255:0] in_state8 = '0;
  logic         in_ready8, out_valid8, out_inv8;
  logic [255:0] out_state8;
  logic [1:0]   occ8;

  logic [256:0] q4[$], q6[$], q8[$];
  logic [127:0] exp4 = '0;
  logic [127:0] held;
  int total = 0;
  int bad = 0;

  localparam logic [127:0] V = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] I = 128'h000d0a0704010e0b0805020f0c090603;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_inv(in_inv4), .in_state(in_state4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_inv(out_inv4), .out_state(out_state4), .occupancy(occ4));

  shift_rows_pipe #(.NB(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(zero), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_inv(in_inv6), .in_state(in_state6), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_inv(out_inv6), .out_state(out_state6), .occupancy(occ6));

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(zero), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_inv(in_inv8), .in_state(in_state8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_inv(out_inv8), .out_state(out_state8), .occupancy(occ8));

  always #5 clk = ~clk;

  // Reference ShiftRows with the row offsets written out independently of the RTL.
  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] s, input bit inv);
    logic [255:0] o;
    int sh, src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
        o[32*nb-8-8*(4*c+r) +: 8] = s[32*nb-8-8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] ref4(input logic [127:0] s, input bit inv);
    logic [255:0] t;
    t = ref_perm(4, {128'b0, s}, inv);
    return t[127:0];
  endfunction

  task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv4(input logic v, input logic inv, input logic [127:0] st, input logic [127:0] ex);
    in_valid4 = v;
    in_inv4   = inv;
    in_state4 = st;
    exp4      = ex;
  endtask

  // Advance one clock: record accepted inputs at the negedge, return at posedge+1.
  task automatic cyc();
    @(negedge clk);
    if (rst_n) begin
      if (flush) q4.delete();
      else if (in_valid4 && in_ready4) q4.push_back({in_inv4, 128'b0, exp4});
      if (in_valid6 && in_ready6) q6.push_back({in_inv6, ref_perm(6, 256'(in_state6), in_inv6)});
      if (in_valid8 && in_ready8) q8.push_back({in_inv8, ref_perm(8, in_state8, in_inv8)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (q4.size() + q6.size() + q8.size()) != 0; k++) cyc();
    chk("drain_left", 257'(q4.size() + q6.size() + q8.size()), 257'd0);
  endtask

  always @(negedge clk) begin
    logic [256:0] e;
    if (rst_n && out_valid4 && out_ready4 && !flush) begin
      if (q4.size() == 0) chk("nb4_unexpected_out", 257'd1, 257'd0);
      else begin
        e = q4.pop_front();
        chk("nb4_out", {out_inv4, 128'b0, out_state4}, e);
      end
    end
    if (rst_n && out_valid6 && out_ready6) begin
      if (q6.size() == 0) chk("nb6_unexpected_out", 257'd1, 257'd0);
      else begin
        e = q6.pop_front();
        chk("nb6_out", {out_inv6, 64'b0, out_state6}, e);
      end
    end
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("nb8_unexpected_out", 257'd1, 257'd0);
      else begin
        e = q8.pop_front();
        chk("nb8_out", {out_inv8, out_state8}, e);
      end
    end
  end

  initial begin
    logic [255:0] seq8;
    logic [1:0] inv_pat [4];
    logic [127:0] st_pat [4];
    logic [127:0] ex_pat [4];

    // Reset state
    #12;
    chk("rst_occ", 257'(occ4), 257'd0);
    chk("rst_out_valid", 257'(out_valid4), 257'd0);
    chk("rst_out_state", 257'(out_state4), 257'd0);
    chk("rst_in_ready", 257'(in_ready4), 257'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forward vector, one-cycle latency
    out_ready4 = 0;
    drv4(1, 0, V, F);
    cyc();
    drv4(0, 0, '0, '0);
    chk("lat_out_valid", 257'(out_valid4), 257'd1);
    chk("lat_occ", 257'(occ4), 257'd1);
    out_ready4 = 1;
    cyc();
    chk("pop_occ", 257'(occ4), 257'd0);

    // Back-to-back interleaved modes; inverse and round trips
    st_pat = '{V, V, F, I};
    inv_pat = '{2'd0, 2'd1, 2'd1, 2'd0};
    ex_pat = '{F, I, V, V};
    for (int k = 0; k < 4; k++) begin
      drv4(1, inv_pat[k][0], st_pat[k], ex_pat[k]);
      chk("b2b_in_ready", 257'(in_ready4), 257'd1);
      cyc();
    end
    drv4(0, 0, '0, '0);
    drain();

    // Backpressure: third push blocked, head stable, in_ready back a cycle after pop
    out_ready4 = 0;
    drv4(1, 0, V, F);
    cyc();
    drv4(1, 1, V, I);
    cyc();
    drv4(1, 1, F, V);
    cyc();
    chk("bp_occ", 257'(occ4), 257'd2);
    chk("bp_in_ready", 257'(in_ready4), 257'd0);
    held = out_state4;
    cyc();
    chk("bp_stable", 257'(out_state4), 257'(held));
    chk("bp_head", {out_inv4, 128'b0, out_state4}, {1'b0, 128'b0, F});
    out_ready4 = 1;
    cyc();
    chk("bp_in_ready_rise", 257'(in_ready4), 257'd1);
    chk("bp_occ_after_pop", 257'(occ4), 257'd1);
    cyc();
    drv4(0, 0, '0, '0);
    drain();

    // Flush with a full buffer and a concurrent input
    out_ready4 = 0;
    drv4(1, 0, V, F);
    cyc();
    drv4(1, 0, I, ref4(I, 0));
    cyc();
    drv4(1, 1, F, V);
    flush = 1;
    cyc();
    flush = 0;
    drv4(0, 0, '0, '0);
    chk("flush_occ", 257'(occ4), 257'd0);
    chk("flush_out_valid", 257'(out_valid4), 257'd0);
    cyc();
    chk("flush_dropped", 257'(out_valid4), 257'd0);

    // NB=6 and NB=8 against the reference model
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = 8'(k);
    in_valid8 = 1; in_inv8 = 0; in_state8 = seq8;
    in_valid6 = 1; in_inv6 = 0; in_state6 = seq8[191:0];
    cyc();
    for (int i = 0; i < 6; i++) begin
      in_inv6 = i[0];
      in_inv8 = ~i[0];
      for (int w = 0; w < 6; w++) in_state6[32*w +: 32] = $urandom;
      for (int w = 0; w < 8; w++) in_state8[32*w +: 32] = $urandom;
      cyc();
    end
    in_valid6 = 0;
    in_valid8 = 0;
    drain();

    // Asynchronous reset mid-stream
    out_ready4 = 0;
    drv4(1, 0, V, F);
    cyc();
    drv4(1, 1, V, I);
    cyc();
    drv4(0, 0, '0, '0);
    #2 rst_n = 0;
    #1;
    chk("arst_occ", 257'(occ4), 257'd0);
    chk("arst_out_valid", 257'(out_valid4), 257'd0);
    chk("arst_out", {out_inv4, 128'b0, out_state4}, 257'd0);
    q4.delete();
    q6.delete();
    q8.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", 257'(in_ready4), 257'd1);
    drv4(1, 1, V, I);
    cyc();
    drv4(0, 0, '0, '0);
    chk("arst_lat_valid", 257'(out_valid4), 257'd1);
    out_ready4 = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
